addsub_seq: RTL

//   Parametrised multi-cycle adder/subtractor with an accumulator for the calculator datapath.

---
 rtl/addsub_seq_if.sv | 27 ++
 rtl/addsub_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/addsub_seq_if.sv
// Request/response bundle for the sequential adder/subtractor.
// master = operand source and result consumer; slave = addsub_seq.
interface addsub_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, ovf, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, ovf, zero
  );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle add/sub/accumulate unit: CHUNK bits per cycle with a registered ripple carry,
// valid/ready on both sides, result and flags held until the next operation completes.
module addsub_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input logic         clk,
  input logic         rst_n,
  addsub_seq_if.slave bus
);

  localparam int unsigned     NCH     = WIDTH / CHUNK;
  localparam int unsigned     CntW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NCH - 1);

  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAcc = 2'b10;
  localparam logic [1:0] OpClr = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // Operands shift right each RUN cycle, so the active chunk is always the low CHUNK bits.
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             c_out, c_msb;
  logic [WIDTH-1:0] sum_next;

  assign a_ch = opa_q[CHUNK-1:0];
  assign b_ch = opb_q[CHUNK-1:0];
  assign {c_out, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, cy_q};
  // Carry into the top bit of the chunk, recovered from the sum bit.
  assign c_msb = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ s_ch[CHUNK-1];
  // Chunk sums enter at the top; after NCH cycles the first chunk has reached bit 0.
  assign sum_next = (sum_q >> CHUNK) | (WIDTH'(s_ch) << (WIDTH - CHUNK));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cy_d     = cy_q;
    sum_d    = sum_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    acc_d    = acc_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (bus.op == OpClr) begin
            result_d = '0;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            zero_d   = 1'b1;
            acc_d    = '0;
            state_d  = StDone;
          end else begin
            opa_d   = (bus.op == OpAcc) ? acc_q : bus.a;
            opb_d   = (bus.op == OpSub) ? ~bus.b : bus.b;
            cy_d    = (bus.op == OpSub);
            cnt_d   = '0;
            state_d = StRun;
          end
        end
      end

      StRun: begin
        opa_d = opa_q >> CHUNK;
        opb_d = opb_q >> CHUNK;
        cy_d  = c_out;
        sum_d = sum_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          result_d = sum_next;
          carry_d  = c_out;
          ovf_d    = c_msb ^ c_out;
          zero_d   = (sum_next == '0);
          acc_d    = sum_next;
          state_d  = StDone;
        end
      end

      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cy_q     <= 1'b0;
      sum_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cy_q     <= cy_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      acc_q    <= acc_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule
